// File: rtl/scan_reg_bank.sv
// Scannable parallel-load register bank with a cp-strobed update, serial scan
// chain, and a scan_full pulse once every WIDTH consecutive shifts complete.
module scan_reg_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EDGE  = 1
) (
  input  logic             sys_clk,
  input  logic             cd,
  input  logic             cp,
  input  logic [WIDTH-1:0] d,
  input  logic             te,
  input  logic             ti,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             so,
  output logic             scan_full
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    shcnt_q, shcnt_d;
  logic             full_q, full_d;
  logic             cp_prev_q;
  logic             upd_c;

  // cp_prev resets high so a cp already high at reset release is not an edge
  assign upd_c = (EDGE != 0) ? (cp & ~cp_prev_q) : cp;

  always_comb begin
    q_d     = q_q;
    shcnt_d = shcnt_q;
    full_d  = 1'b0;
    if (upd_c) begin
      if (te) begin
        q_d = {q_q[WIDTH-2:0], ti};
        if (shcnt_q == LAST_CNT) begin
          shcnt_d = '0;
          full_d  = 1'b1;
        end else begin
          shcnt_d = CW'(shcnt_q + 1'b1);
        end
      end else begin
        q_d     = d;
        shcnt_d = '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge cd) begin
    if (!cd) begin
      q_q       <= '0;
      shcnt_q   <= '0;
      full_q    <= 1'b0;
      cp_prev_q <= 1'b1;
    end else begin
      q_q       <= q_d;
      shcnt_q   <= shcnt_d;
      full_q    <= full_d;
      cp_prev_q <= cp;
    end
  end

  assign q         = q_q;
  assign qn        = ~q_q;
  assign so        = q_q[WIDTH-1];
  assign scan_full = full_q;

endmodule

// File: tb/tb_scan_reg_bank.sv
// Scoreboard bench for scan_reg_bank: an edge-mode and a level-mode instance.
module tb_scan_reg_bank;

  typedef struct packed {
    logic [7:0] q;
    logic       sf;
  } exp_t;

  logic       clk;
  logic       cd, cp, te, ti;
  logic [7:0] d, q, qn;
  logic       so, sf;
  logic       l_cd, l_cp, l_te, l_ti;
  logic [7:0] l_d, l_q, l_qn;
  logic       l_so, l_sf;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  scan_reg_bank #(.WIDTH(8), .EDGE(1)) dut_e (
    .sys_clk(clk), .cd(cd), .cp(cp), .d(d), .te(te), .ti(ti),
    .q(q), .qn(qn), .so(so), .scan_full(sf)
  );

  scan_reg_bank #(.WIDTH(8), .EDGE(0)) dut_l (
    .sys_clk(clk), .cd(l_cd), .cp(l_cp), .d(l_d), .te(l_te), .ti(l_ti),
    .q(l_q), .qn(l_qn), .so(l_so), .scan_full(l_sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_e(input logic c, input logic t, input logic s, input logic [7:0] dv);
    cp = c; te = t; ti = s; d = dv;
    @(posedge clk); #1;
  endtask

  task automatic step_l(input logic c, input logic t, input logic s, input logic [7:0] dv);
    l_cp = c; l_te = t; l_ti = s; l_d = dv;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] qv, input logic sv);
    exp_t e;
    e.q = qv; e.sf = sv;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    cd = 1'b1; cp = 1'b1; te = 1'b0; ti = 1'b1; d = 8'hFF;
    l_cd = 1'b1; l_cp = 1'b0; l_te = 1'b0; l_ti = 1'b0; l_d = 8'h00;
    #2;
    cd = 1'b0; l_cd = 1'b0;
    #1;
    n_chk++;
    if ({q, qn, so, sf} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got q=%h qn=%h so=%b full=%b want q=00 qn=ff so=0 full=0", q, qn, so, sf);
    end
    @(posedge clk); #1;
    // reset must dominate a cp strobe with load data present
    for (int i = 0; i < 2; i++) begin
      push(8'h00, 1'b0);
      step_e(i[0], 1'b0, 1'b1, 8'hFF);
      e = sb.pop_front(); n_chk++;
      if ({q, qn, so, sf} !== {e.q, ~e.q, e.q[7], e.sf}) begin
        n_fail++;
        $display("FAIL reset_dominate[%0d]: got q=%h full=%b want q=%h full=%b", i, q, sf, e.q, e.sf);
      end
    end
    cd = 1'b1; l_cd = 1'b1;
    // cp already high at release: no update until it goes low then high
    for (int i = 0; i < 6; i++) begin
      push((i >= 4) ? 8'hFF : 8'h00, 1'b0);
      step_e((i == 3 || i == 5) ? 1'b0 : 1'b1, 1'b0, 1'b0, 8'hFF);
      e = sb.pop_front(); n_chk++;
      if ({q, qn, so, sf} !== {e.q, ~e.q, e.q[7], e.sf}) begin
        n_fail++;
        $display("FAIL release_cp_high[%0d]: got q=%h full=%b want q=%h full=%b", i, q, sf, e.q, e.sf);
      end
    end
  endtask

  task automatic test_load();
    exp_t e;
    // cp held high 5 cycles; d changes after the first, must not be captured
    for (int i = 0; i < 6; i++) begin
      push(8'hA5, 1'b0);
      step_e((i < 5) ? 1'b1 : 1'b0, 1'b0, 1'b0, (i == 0) ? 8'hA5 : 8'h33);
      e = sb.pop_front(); n_chk++;
      if ({q, qn, so, sf} !== {e.q, ~e.q, e.q[7], e.sf}) begin
        n_fail++;
        $display("FAIL load_hold[%0d]: got q=%h qn=%h so=%b full=%b want q=%h full=%b", i, q, qn, so, sf, e.q, e.sf);
      end
    end
    n_chk++;
    if ({qn, so} !== {8'h5A, 1'b1}) begin
      n_fail++;
      $display("FAIL load_qn_so: got qn=%h so=%b want qn=5a so=1", qn, so);
    end
  endtask

  task automatic test_shift();
    exp_t e;
    logic [7:0] m;
    bit pat [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    step_e(1'b1, 1'b0, 1'b0, 8'h00);
    step_e(1'b0, 1'b0, 1'b0, 8'h00);
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m = {m[6:0], pat[i]};
      for (int ph = 0; ph < 2; ph++) begin
        push(m, (ph == 0) && (i == 7));
        // low phase flips te/d/ti: must have no effect until the next strobe
        if (ph == 0) step_e(1'b1, 1'b1, pat[i], 8'h00);
        else         step_e(1'b0, 1'b0, ~pat[i], 8'hFF);
        e = sb.pop_front(); n_chk++;
        if ({q, qn, so, sf} !== {e.q, ~e.q, e.q[7], e.sf}) begin
          n_fail++;
          $display("FAIL shift[%0d.%0d]: got q=%h full=%b want q=%h full=%b", i, ph, q, sf, e.q, e.sf);
        end
      end
    end
    n_chk++;
    if (q !== 8'hB2) begin
      n_fail++;
      $display("FAIL shift_final: got q=%h want q=b2", q);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [7:0] m;
    step_e(1'b1, 1'b0, 1'b0, 8'h00);
    step_e(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step_e(1'b1, 1'b1, 1'b1, 8'h00);
      step_e(1'b0, 1'b1, 1'b1, 8'h00);
    end
    n_chk++;
    if (q !== 8'h1F) begin
      n_fail++;
      $display("FAIL pre_reset_shift: got q=%h want q=1f", q);
    end
    cd = 1'b0;
    #2;
    n_chk++;
    if ({q, sf} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got q=%h full=%b want q=00 full=0", q, sf);
    end
    cd = 1'b1;
    push(8'h00, 1'b0);
    step_e(1'b0, 1'b1, 1'b1, 8'h00);
    e = sb.pop_front(); n_chk++;
    if ({q, sf} !== {e.q, e.sf}) begin
      n_fail++;
      $display("FAIL post_reset_idle: got q=%h full=%b want q=%h full=%b", q, sf, e.q, e.sf);
    end
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m = {m[6:0], 1'b1};
      for (int ph = 0; ph < 2; ph++) begin
        push(m, (ph == 0) && (i == 7));
        step_e((ph == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1, 8'h00);
        e = sb.pop_front(); n_chk++;
        if ({q, qn, so, sf} !== {e.q, ~e.q, e.q[7], e.sf}) begin
          n_fail++;
          $display("FAIL reset_restart[%0d.%0d]: got q=%h full=%b want q=%h full=%b", i, ph, q, sf, e.q, e.sf);
        end
      end
    end
  endtask

  task automatic test_load_clears();
    exp_t e;
    logic [7:0] m;
    m = q;
    for (int i = 0; i < 12; i++) begin
      // 3 shifts, one load of 3C, then 8 shifts of zero
      if (i == 3) m = 8'h3C;
      else        m = {m[6:0], 1'b0};
      for (int ph = 0; ph < 2; ph++) begin
        push(m, (ph == 0) && (i == 11));
        step_e((ph == 0) ? 1'b1 : 1'b0, (i != 3), 1'b0, 8'h3C);
        e = sb.pop_front(); n_chk++;
        if ({q, qn, so, sf} !== {e.q, ~e.q, e.q[7], e.sf}) begin
          n_fail++;
          $display("FAIL load_clears[%0d.%0d]: got q=%h full=%b want q=%h full=%b", i, ph, q, sf, e.q, e.sf);
        end
      end
    end
  endtask

  task automatic test_level();
    exp_t e;
    logic [7:0] m;
    step_l(1'b1, 1'b0, 1'b0, 8'h00);
    m = 8'h00;
    for (int i = 0; i < 10; i++) begin
      // cp high 3 cycles, low 1, high 5 more, low 1
      logic c;
      c = (i != 3) && (i != 9);
      if (c) m = {m[6:0], 1'b1};
      push(m, (i == 8));
      step_l(c, 1'b1, 1'b1, 8'h00);
      e = sb.pop_front(); n_chk++;
      if ({l_q, l_qn, l_so, l_sf} !== {e.q, ~e.q, e.q[7], e.sf}) begin
        n_fail++;
        $display("FAIL level[%0d]: got q=%h full=%b want q=%h full=%b", i, l_q, l_sf, e.q, e.sf);
      end
      if (i == 2) begin
        n_chk++;
        if ({l_q, dut_l.shcnt_q, l_sf} !== {8'h07, 3'd3, 1'b0}) begin
          n_fail++;
          $display("FAIL level_three: got q=%h shcnt=%0d full=%b want q=07 shcnt=3 full=0", l_q, dut_l.shcnt_q, l_sf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_reset_mid();
    test_load_clears();
    test_level();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_reg_bank.md
SCAN_REG_BANK -- requirements
Module: scan_reg_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL provide parameter EDGE, default 1: 1 = update on detected rising edge of cp; 0 = update on every sys_clk cycle while cp high (legacy level mode).
REQ-003 SHALL provide port sys_clk input 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port cd input 1: asynchronous active-low clear/reset.
REQ-005 SHALL provide port cp input 1: functional clock-enable strobe, synchronous to sys_clk.
REQ-006 SHALL provide port d input WIDTH: parallel load data.
REQ-007 SHALL provide port te input 1: scan enable; 0 = parallel mode, 1 = shift mode.
REQ-008 SHALL provide port ti input 1: serial scan-in bit.
REQ-009 SHALL provide port q output WIDTH: register contents.
REQ-010 SHALL provide port qn output WIDTH: bitwise inverse of q, always.
REQ-011 SHALL provide port so output 1: serial scan-out, equal to q[WIDTH-1].
REQ-012 SHALL provide port scan_full output 1: one-cycle pulse when WIDTH consecutive shifts have completed.

Function
REQ-013 SHALL register cp each sys_clk into cp_prev; update strobe upd = cp & ~cp_prev when EDGE=1, upd = cp when EDGE=0.
REQ-014 SHALL leave q, counter and scan_full-source state unchanged on cycles with upd=0.
REQ-015 SHALL load q <= d on the sys_clk edge where upd=1 and te=0.
REQ-016 SHALL shift q <= {q[WIDTH-2:0], ti} on the sys_clk edge where upd=1 and te=1.
REQ-017 Latency: q reflects the load/shift one sys_clk after the cycle in which upd is sampled high; with EDGE=1 that is the cycle cp is first seen high.
REQ-018 SHALL hold shift counter shcnt, width clog2(WIDTH), counting shift operations.
REQ-019 SHALL increment shcnt on each shift; on the shift taking shcnt from WIDTH-1, SHALL wrap shcnt to 0 and assert scan_full for exactly the next sys_clk cycle.
REQ-020 SHALL clear shcnt to 0 on any parallel load (upd=1, te=0); scan_full not asserted by loads.
REQ-021 te changing between strobes SHALL take effect at the next strobe only; te change alone SHALL NOT alter q or shcnt.
REQ-022 EDGE=1, cp held high across many cycles: exactly one update per low-to-high transition.
REQ-023 EDGE=0: cp held high N cycles SHALL perform N updates (N shifts in shift mode, counter advancing each).
REQ-024 so and qn SHALL be combinational functions of q with no added latency.

Reset
REQ-025 cd=0 SHALL asynchronously force q=0, qn=all ones, so=0, shcnt=0, scan_full=0, cp_prev=1, independent of sys_clk.
REQ-026 cp_prev reset value 1 SHALL prevent a spurious edge if cp is already high at reset release; first update needs cp to go low then high (EDGE=1).
REQ-027 cd asserted mid-shift-sequence SHALL discard the partial count; after release a full WIDTH shifts is needed for scan_full.
REQ-028 cd=0 SHALL dominate cp, te, d, ti in the same cycle.

Verification (WIDTH=8)
REQ-029 EDGE=1, te=0, d=0xA5, cp pulsed 0->1 and held 5 cycles -> q=0xA5 after one cycle, unchanged thereafter, qn=0x5A, so=1.
REQ-030 EDGE=1, q=0x00, te=1, ti pattern 1,0,1,1,0,0,1,0 over 8 cp pulses -> q=0xB2, scan_full high exactly one cycle after 8th shift, low otherwise.
REQ-031 EDGE=0, te=1, ti=1, q=0x00, cp high 3 cycles -> q=0x07, shcnt=3, scan_full=0.
REQ-032 After 5 shifts, cd pulsed low for less than one sys_clk period (between edges) -> q=0x00 immediately; 8 further shifts required for scan_full.
REQ-033 cd released with cp=1, EDGE=1, te=0, d=0xFF -> q stays 0x00 until cp goes low then high, then q=0xFF.
REQ-034 3 shifts, then a parallel load d=0x3C, then 8 shifts -> scan_full asserts only after the 8th post-load shift.
